// File: rtl/microc_pkg.sv
// Shared constants and types for the microc control unit: opcode map,
// sequencer state encoding and the packed control word.
package microc_pkg;

    localparam int CNT_W_DEF = 16;

    // Upper two bits of any load-immediate opcode.
    localparam logic [1:0] OP_LI_PFX = 2'b10;

    localparam logic [5:0] OP_J    = 6'b110000;
    localparam logic [5:0] OP_JZ   = 6'b110001;
    localparam logic [5:0] OP_JNZ  = 6'b110010;
    localparam logic [5:0] OP_NOP  = 6'b111110;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_NONE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we;
        logic       wez;
        logic [2:0] alu_op;
    } ctrl_t;

    // Safe control word: PC+1 selected, no writes, ALU op 0.
    localparam ctrl_t CTRL_IDLE = '{s_inc: 1'b1, s_inm: 1'b0, we: 1'b0,
                                    wez: 1'b0, alu_op: ALU_NONE};

endpackage

// File: rtl/microc_sequencer_if.sv
// Datapath/debug side of the microc sequencer. The sequencer takes the
// slave view; whoever drives opcodes and debug controls takes the master view.
interface microc_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       Opcode;
    logic             zero;
    logic             run;
    logic             step;
    logic             halt_req;
    logic             clear;

    logic             s_inc;
    logic             s_inm;
    logic             we;
    logic             wez;
    logic             pc_we;
    logic [2:0]       AluOP;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output Opcode, zero, run, step, halt_req, clear,
        input  s_inc, s_inm, we, wez, pc_we, AluOP, halted, illegal, instr_count
    );

    modport slave (
        input  Opcode, zero, run, step, halt_req, clear,
        output s_inc, s_inm, we, wez, pc_we, AluOP, halted, illegal, instr_count
    );

endinterface

// File: rtl/microc_decode.sv
// Pure combinational instruction decode: opcode and zero flag to control
// word, plus flags for the HALT opcode and for unassigned 11xxxx opcodes.
module microc_decode
    import microc_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    output ctrl_t      ctrl_o,
    output logic       is_halt_o,
    output logic       is_illegal_o
);

    // Opcode map; halt/illegal leave the safe control word in place.
    always_comb begin
        ctrl_o       = CTRL_IDLE;
        is_halt_o    = 1'b0;
        is_illegal_o = 1'b0;
        if (opcode_i[5] == 1'b0) begin
            ctrl_o.alu_op = opcode_i[4:2];
            ctrl_o.we     = 1'b1;
            ctrl_o.wez    = 1'b1;
        end else if (opcode_i[5:4] == OP_LI_PFX) begin
            ctrl_o.s_inm = 1'b1;
            ctrl_o.we    = 1'b1;
        end else begin
            case (opcode_i)
                OP_J:    ctrl_o.s_inc = 1'b0;
                OP_JZ:   ctrl_o.s_inc = ~zero_i;
                OP_JNZ:  ctrl_o.s_inc = zero_i;
                OP_NOP:  ctrl_o.s_inc = 1'b1;
                OP_HALT: is_halt_o    = 1'b1;
                default: is_illegal_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/microc_sequencer.sv
// microc control unit: instruction decode gated by a run/step/halt FSM,
// PC write enable, sticky illegal-opcode flag and retired-instruction counter.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | CPU frozen, waiting for step or run
//  RUN     | executing one instruction per cycle while run stays high
//  STEP    | executing exactly one instruction, then back to IDLE
//  HALT    | stopped on HALT/illegal opcode; only clear leaves
module microc_sequencer
    import microc_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter bit AUTORUN = 1'b0
) (
    input logic               clk,
    input logic               reset,
    microc_sequencer_if.slave seq
);

    localparam seq_state_e RESET_STATE = AUTORUN ? ST_RUN : ST_IDLE;

    seq_state_e       state_q, state_d;
    logic             halted_q, halted_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;

    ctrl_t            dec_ctrl;
    logic             dec_halt;
    logic             dec_illegal;
    ctrl_t            ctrl;
    logic             pc_we;
    logic             retire;
    logic             run_eff;

    microc_decode u_decode (
        .opcode_i     (seq.Opcode),
        .zero_i       (seq.zero),
        .ctrl_o       (dec_ctrl),
        .is_halt_o    (dec_halt),
        .is_illegal_o (dec_illegal)
    );

    assign run_eff = seq.run | AUTORUN;

    // Next state, gated controls and retirement; reset forces the safe word.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        ctrl      = CTRL_IDLE;
        pc_we     = 1'b0;
        retire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (seq.step) begin
                    state_d = ST_STEP;
                end else if (run_eff) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_STEP: begin
                if (dec_halt || dec_illegal) begin
                    state_d = ST_HALT;
                    if (dec_illegal) begin
                        illegal_d = 1'b1;
                    end
                end else begin
                    ctrl   = dec_ctrl;
                    pc_we  = 1'b1;
                    retire = 1'b1;
                    if (state_q == ST_STEP || seq.halt_req || !run_eff) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HALT: begin
                if (seq.clear) begin
                    state_d   = ST_IDLE;
                    illegal_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (reset) begin
            ctrl   = CTRL_IDLE;
            pc_we  = 1'b0;
            retire = 1'b0;
        end
        halted_d = (state_d == ST_HALT);
        count_d  = count_q + {{(CNT_W-1){1'b0}}, retire};
    end

    // State, status flags and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RESET_STATE;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    assign seq.s_inc       = ctrl.s_inc;
    assign seq.s_inm       = ctrl.s_inm;
    assign seq.we          = ctrl.we;
    assign seq.wez         = ctrl.wez;
    assign seq.AluOP       = ctrl.alu_op;
    assign seq.pc_we       = pc_we;
    assign seq.halted      = halted_q;
    assign seq.illegal     = illegal_q;
    assign seq.instr_count = count_q;

endmodule

// File: tb/tb_microc_sequencer.sv
// Self-checking bench for microc_sequencer: directed scenarios plus a random
// soak, all checked against a behavioural model of the sequencer rules.
module tb_microc_sequencer;

    localparam logic [5:0] LI   = 6'b100000;
    localparam logic [5:0] ADD  = 6'b001000;
    localparam logic [5:0] J    = 6'b110000;
    localparam logic [5:0] JZ   = 6'b110001;
    localparam logic [5:0] JNZ  = 6'b110010;
    localparam logic [5:0] NOP  = 6'b111110;
    localparam logic [5:0] HLT  = 6'b111111;
    localparam logic [5:0] ILL  = 6'b110111;

    logic clk = 1'b0;
    logic reset;
    logic a_reset;

    always #5 clk = ~clk;

    microc_sequencer_if #(.CNT_W(4)) bus ();
    microc_sequencer #(.CNT_W(4), .AUTORUN(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .seq   (bus)
    );

    microc_sequencer_if #(.CNT_W(16)) abus ();
    microc_sequencer #(.CNT_W(16), .AUTORUN(1'b1)) dut_auto (
        .clk   (clk),
        .reset (a_reset),
        .seq   (abus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Stimulus vector: {reset, clear, halt_req, step, run, zero, Opcode}.
    logic [11:0] cur;

    // Behavioural model: what the CPU is doing, not how the RTL encodes it.
    logic m_active;   // free-running
    logic m_single;   // one pending single-step instruction
    logic m_halted;
    logic m_ill;
    int   m_cnt;      // retired instructions modulo 16

    function automatic logic [11:0] V(input logic rst, input logic clr, input logic hlt,
                                      input logic stp, input logic rn, input logic z,
                                      input logic [5:0] op);
        return {rst, clr, hlt, stp, rn, z, op};
    endfunction

    function automatic bit is_stop_op(input int o);
        return (o >= 48) && !(o == 48 || o == 49 || o == 50 || o == 62);
    endfunction

    // Expected {pc_we, s_inc, s_inm, we, wez, AluOP}.
    function automatic logic [7:0] exp_ctrl();
        int   o;
        logic z;
        o = int'(cur[5:0]);
        z = cur[6];
        if (cur[11] || m_halted || !(m_active || m_single)) return 8'b0100_0000;
        if (o < 32)  return {5'b11011, 3'(o / 4)};
        if (o < 48)  return 8'b1111_0000;
        if (o == 48) return 8'b1000_0000;
        if (o == 49) return {1'b1, ~z, 6'b000000};
        if (o == 50) return {1'b1, z, 6'b000000};
        if (o == 62) return 8'b1100_0000;
        return 8'b0100_0000;
    endfunction

    function automatic logic [7:0] got_ctrl();
        return {bus.pc_we, bus.s_inc, bus.s_inm, bus.we, bus.wez, bus.AluOP};
    endfunction

    function automatic logic [5:0] exp_stat();
        return {m_halted, m_ill, 4'(m_cnt)};
    endfunction

    function automatic logic [5:0] got_stat();
        return {bus.halted, bus.illegal, bus.instr_count};
    endfunction

    task automatic model_edge();
        int o;
        o = int'(cur[5:0]);
        if (cur[11]) begin
            m_active = 1'b0; m_single = 1'b0; m_halted = 1'b0; m_ill = 1'b0; m_cnt = 0;
        end else if (m_halted) begin
            if (cur[10]) begin
                m_halted = 1'b0;
                m_ill    = 1'b0;
            end
        end else if (m_active || m_single) begin
            if (is_stop_op(o)) begin
                m_halted = 1'b1; m_active = 1'b0; m_single = 1'b0;
                if (o != 63) m_ill = 1'b1;
            end else begin
                m_cnt = (m_cnt + 1) % 16;
                if (m_single) m_single = 1'b0;
                else if (cur[9] || !cur[7]) m_active = 1'b0;
            end
        end else if (cur[8]) begin
            m_single = 1'b1;
        end else if (cur[7]) begin
            m_active = 1'b1;
        end
    endtask

    task automatic apply(input logic [11:0] v);
        @(negedge clk);
        {reset, bus.clear, bus.halt_req, bus.step, bus.run, bus.zero, bus.Opcode} = v;
        cur = v;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        apply(V(1, 0, 0, 0, 1, 0, LI));
        n_vec++;
        if (got_ctrl() !== 8'b0100_0000) begin
            $display("FAIL reset_ctrl got=%b exp=%b", got_ctrl(), 8'b0100_0000); n_err++;
        end
        tick();
        n_vec++;
        if (got_stat() !== 6'b00_0000) begin
            $display("FAIL reset_stat got=%b exp=%b", got_stat(), 6'b00_0000); n_err++;
        end
    endtask

    task automatic test_program();
        logic [11:0] prog [4];
        int          start;
        prog[0] = V(0, 0, 0, 0, 1, 0, LI);
        prog[1] = V(0, 0, 0, 0, 1, 0, LI);
        prog[2] = V(0, 0, 0, 0, 1, 0, LI);
        prog[3] = V(0, 0, 0, 0, 0, 0, ADD);
        start = m_cnt;
        foreach (prog[i]) begin
            apply(prog[i]);
            n_vec++;
            if (got_ctrl() !== exp_ctrl()) begin
                $display("FAIL prog_ctrl i=%0d got=%b exp=%b", i, got_ctrl(), exp_ctrl()); n_err++;
            end
            if (i == 3) begin
                n_vec++;
                if (got_ctrl() !== 8'b1101_1010) begin
                    $display("FAIL prog_add got=%b exp=%b", got_ctrl(), 8'b1101_1010); n_err++;
                end
            end
            tick();
            n_vec++;
            if (got_stat() !== exp_stat()) begin
                $display("FAIL prog_stat i=%0d got=%b exp=%b", i, got_stat(), exp_stat()); n_err++;
            end
        end
        n_vec++;
        if (int'(bus.instr_count) !== (start + 3) % 16) begin
            $display("FAIL prog_count got=%0d exp=%0d", bus.instr_count, (start + 3) % 16); n_err++;
        end
    endtask

    task automatic test_step();
        int pulses = 0;
        int start;
        logic [5:0] op;
        start = m_cnt;
        for (int k = 0; k < 12; k++) begin
            op = 6'($urandom_range(0, 47));
            apply(V(0, 0, 0, (k % 4) == 0, 0, 1'($urandom), op));
            n_vec++;
            if (got_ctrl() !== exp_ctrl()) begin
                $display("FAIL step_ctrl k=%0d got=%b exp=%b", k, got_ctrl(), exp_ctrl()); n_err++;
            end
            if (bus.pc_we) pulses++;
            tick();
        end
        n_vec++;
        if (pulses !== 3) begin
            $display("FAIL step_pulses got=%0d exp=3", pulses); n_err++;
        end
        n_vec++;
        if (int'(bus.instr_count) !== (start + 3) % 16) begin
            $display("FAIL step_count got=%0d exp=%0d", bus.instr_count, (start + 3) % 16); n_err++;
        end
    endtask

    task automatic test_jumps();
        logic [11:0] prog [5];
        logic [7:0]  fixed [5];
        prog[0] = V(0, 0, 0, 0, 1, 0, NOP);  fixed[0] = 8'b0100_0000;
        prog[1] = V(0, 0, 0, 0, 1, 1, JZ);   fixed[1] = 8'b1000_0000;
        prog[2] = V(0, 0, 0, 0, 1, 1, JNZ);  fixed[2] = 8'b1100_0000;
        prog[3] = V(0, 0, 0, 0, 1, 0, J);    fixed[3] = 8'b1000_0000;
        prog[4] = V(0, 0, 1, 0, 1, 0, JZ);   fixed[4] = 8'b1100_0000;
        foreach (prog[i]) begin
            apply(prog[i]);
            n_vec++;
            if (got_ctrl() !== fixed[i] || got_ctrl() !== exp_ctrl()) begin
                $display("FAIL jump_ctrl i=%0d got=%b exp=%b", i, got_ctrl(), fixed[i]); n_err++;
            end
            tick();
            n_vec++;
            if (got_stat() !== exp_stat()) begin
                $display("FAIL jump_stat i=%0d got=%b exp=%b", i, got_stat(), exp_stat()); n_err++;
            end
        end
    endtask

    task automatic test_halt(input logic [5:0] stop_op, input logic exp_ill);
        int start;
        start = m_cnt;
        apply(V(0, 0, 0, 0, 1, 0, NOP));
        tick();
        apply(V(0, 0, 0, 0, 1, 0, stop_op));
        n_vec++;
        if ({bus.pc_we, bus.we, bus.wez} !== 3'b000) begin
            $display("FAIL halt_nowrite op=%b got=%b exp=000", stop_op, {bus.pc_we, bus.we, bus.wez}); n_err++;
        end
        tick();
        n_vec++;
        if ({bus.halted, bus.illegal, bus.instr_count} !== {1'b1, exp_ill, 4'(start)}
            || got_stat() !== exp_stat()) begin
            $display("FAIL halt_entry op=%b got=%b exp=%b", stop_op, got_stat(), {1'b1, exp_ill, 4'(start)});
            n_err++;
        end
        for (int k = 0; k < 4; k++) begin
            apply(V(0, 0, 1'($urandom), 1'($urandom), 1, 0, 6'($urandom_range(0, 47))));
            n_vec++;
            if (got_ctrl() !== 8'b0100_0000) begin
                $display("FAIL halt_hold_ctrl k=%0d got=%b exp=%b", k, got_ctrl(), 8'b0100_0000); n_err++;
            end
            tick();
            n_vec++;
            if (got_stat() !== exp_stat()) begin
                $display("FAIL halt_hold_stat k=%0d got=%b exp=%b", k, got_stat(), exp_stat()); n_err++;
            end
        end
        apply(V(0, 1, 0, 0, 0, 0, NOP));
        tick();
        n_vec++;
        if ({bus.halted, bus.illegal} !== 2'b00 || got_stat() !== exp_stat()) begin
            $display("FAIL halt_clear got=%b exp=%b", got_stat(), exp_stat()); n_err++;
        end
        apply(V(0, 0, 0, 0, 0, 0, NOP));
        n_vec++;
        if (got_ctrl() !== 8'b0100_0000) begin
            $display("FAIL halt_idle got=%b exp=%b", got_ctrl(), 8'b0100_0000); n_err++;
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        apply(V(0, 0, 0, 0, 1, 0, NOP));
        tick();
        apply(V(0, 0, 0, 0, 1, 0, ADD));
        tick();
        apply(V(1, 0, 0, 0, 1, 0, ADD));
        n_vec++;
        if ({bus.pc_we, bus.we, bus.wez} !== 3'b000) begin
            $display("FAIL rst_mid_writes got=%b exp=000", {bus.pc_we, bus.we, bus.wez}); n_err++;
        end
        tick();
        n_vec++;
        if (got_stat() !== 6'b00_0000) begin
            $display("FAIL rst_mid_stat got=%b exp=%b", got_stat(), 6'b00_0000); n_err++;
        end
        apply(V(0, 0, 0, 0, 1, 0, NOP));
        n_vec++;
        if (got_ctrl() !== 8'b0100_0000) begin
            $display("FAIL rst_mid_idle got=%b exp=%b", got_ctrl(), 8'b0100_0000); n_err++;
        end
        tick();
        for (int k = 0; k < 16; k++) begin
            apply(V(0, 0, 0, 0, 1, 1'($urandom), 6'($urandom_range(0, 47))));
            tick();
            if (k == 14) begin
                n_vec++;
                if (bus.instr_count !== 4'd15) begin
                    $display("FAIL wrap_pre got=%0d exp=15", bus.instr_count); n_err++;
                end
            end
        end
        n_vec++;
        if (bus.instr_count !== 4'd0 || got_stat() !== exp_stat()) begin
            $display("FAIL wrap got=%0d exp=0", bus.instr_count); n_err++;
        end
        apply(V(0, 0, 1, 0, 1, 0, NOP));
        tick();
    endtask

    task automatic test_random();
        logic [5:0] op;
        for (int k = 0; k < 400; k++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(48, 63))
                                              : 6'($urandom_range(0, 47));
            apply(V($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
                    $urandom_range(0, 9) < 6, 1'($urandom), op));
            n_vec++;
            if (got_ctrl() !== exp_ctrl()) begin
                $display("FAIL rand_ctrl k=%0d vec=%b got=%b exp=%b", k, cur, got_ctrl(), exp_ctrl()); n_err++;
            end
            tick();
            n_vec++;
            if (got_stat() !== exp_stat()) begin
                $display("FAIL rand_stat k=%0d vec=%b got=%b exp=%b", k, cur, got_stat(), exp_stat()); n_err++;
            end
        end
    endtask

    task automatic test_autorun();
        @(negedge clk);
        a_reset = 1'b1; abus.Opcode = NOP; abus.run = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        a_reset = 1'b0; #1;
        n_vec++;
        if (abus.pc_we !== 1'b1) begin
            $display("FAIL auto_run got=%b exp=1", abus.pc_we); n_err++;
        end
        @(posedge clk); #1;
        n_vec++;
        if (abus.instr_count !== 16'd1) begin
            $display("FAIL auto_count got=%0d exp=1", abus.instr_count); n_err++;
        end
        @(negedge clk);
        abus.halt_req = 1'b1; #1;
        n_vec++;
        if (abus.pc_we !== 1'b1) begin
            $display("FAIL auto_halt_req got=%b exp=1", abus.pc_we); n_err++;
        end
        @(negedge clk);
        abus.halt_req = 1'b0; #1;
        n_vec++;
        if (abus.pc_we !== 1'b0) begin
            $display("FAIL auto_idle got=%b exp=0", abus.pc_we); n_err++;
        end
        @(negedge clk); #1;
        n_vec++;
        if (abus.pc_we !== 1'b1 || abus.instr_count !== 16'd2) begin
            $display("FAIL auto_resume got=%b/%0d exp=1/2", abus.pc_we, abus.instr_count); n_err++;
        end
    endtask

    initial begin
        reset = 1'b1; a_reset = 1'b1;
        {bus.clear, bus.halt_req, bus.step, bus.run, bus.zero} = '0;
        bus.Opcode = NOP;
        {abus.clear, abus.halt_req, abus.step, abus.run, abus.zero} = '0;
        abus.Opcode = NOP;
        cur = V(1, 0, 0, 0, 0, 0, NOP);
        m_active = 1'b0; m_single = 1'b0; m_halted = 1'b0; m_ill = 1'b0; m_cnt = 0;
        test_reset();
        test_program();
        test_step();
        test_jumps();
        test_halt(HLT, 1'b0);
        test_halt(ILL, 1'b1);
        test_reset_mid_run();
        test_random();
        test_autorun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
